// File: rtl/riscv_fetch_stage.sv
// RISC-V instruction-fetch front end: owns the PC, issues word reads to imem,
// buffers returned instructions and hands {pc, instr} to decode; redirects flush.
module riscv_fetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W+1)'(DEPTH);

    typedef enum logic {FETCH = 1'b0, FLUSH = 1'b1} state_t;

    state_t r_state, w_state_next;

    logic [XLEN-1:0]  r_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_head, r_tail;
    logic [PTR_W-1:0] r_if_rd, r_if_wr;
    logic [XLEN-1:0]  r_buf_pc    [DEPTH];
    logic [XLEN-1:0]  r_buf_instr [DEPTH];
    logic [XLEN-1:0]  r_if_pc     [DEPTH];

    logic             w_fire;
    logic             w_push;
    logic             w_pop;
    logic             w_credit_ok;
    logic [CNT_W:0]   w_occupied;
    logic [CNT_W-1:0] w_pending;
    logic [XLEN-1:0]  w_redirect_target;

    // Buffered entries plus in-flight requests may never exceed DEPTH; a pop in
    // the same cycle is deliberately not credited to keep this path short.
    assign w_occupied  = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_credit_ok = w_occupied < DEPTH_W;

    assign w_fire            = imem_req_valid & imem_req_ready;
    assign w_pending         = r_outstanding - CNT_W'(imem_rsp_valid);
    assign w_redirect_target = redirect_pc & ~XLEN'(3);

    assign w_push = imem_rsp_valid & (r_state == FETCH) & ~redirect_valid;
    assign w_pop  = id_valid & id_ready & ~redirect_valid;

    assign imem_req_addr = r_pc;
    assign id_valid      = (r_count != '0);
    assign id_pc         = r_buf_pc[r_head];
    assign id_instr      = r_buf_instr[r_head];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FETCH;
        else        r_state <= w_state_next;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        if (redirect_valid)
            w_state_next = (w_pending != '0) ? FLUSH : FETCH;
        else if (r_state == FLUSH && imem_rsp_valid && r_outstanding == CNT_W'(1))
            w_state_next = FETCH;
    end

    // Gating with rst_n keeps the request low while reset is held.
    always_comb begin
        imem_req_valid = 1'b0;
        if (rst_n && r_state == FETCH && !redirect_valid && w_credit_ok)
            imem_req_valid = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_if_rd       <= '0;
            r_if_wr       <= '0;
        end else begin
            if (redirect_valid)
                r_pc <= w_redirect_target;
            else if (w_fire)
                r_pc <= r_pc + XLEN'(4);
            r_outstanding <= r_outstanding + CNT_W'(w_fire) - CNT_W'(imem_rsp_valid);
            if (w_fire)
                r_if_wr <= r_if_wr + PTR_W'(1);
            if (imem_rsp_valid)
                r_if_rd <= r_if_rd + PTR_W'(1);
        end
    end

    // NOTE: the in-flight PC table has no reset; an entry is always written on
    // fire before its response can read it, so reset would only add wiring.
    always_ff @(posedge clk) begin
        if (w_fire)
            r_if_pc[r_if_wr] <= r_pc;
    end

    // The fetch buffer is reset because id_pc/id_instr must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_buf_pc[i]    <= '0;
                r_buf_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_buf_pc[r_tail]    <= r_if_pc[r_if_rd];
                r_buf_instr[r_tail] <= imem_rsp_data;
                r_tail              <= r_tail + PTR_W'(1);
            end
            if (w_pop)
                r_head <= r_head + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Directed bench for riscv_fetch_stage: a table of per-cycle vectors against a
// fixed-latency imem model, plus hand sequences for flush, wrap and async reset.
module tb_riscv_fetch_stage;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    riscv_fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          req_ready;
        bit          id_rdy;
        bit          redir;
        logic [31:0] redir_pc;
        bit          exp_rv;
        logic [31:0] exp_addr;
        bit          exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    vec_t  tbl[$];
    pend_t q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    int    lat         = 1;

    logic        s_rv, s_iv;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0013;
    endfunction

    function automatic vec_t v(input bit rst, input bit rr, input bit ir, input bit rd,
                               input logic [31:0] rpc, input bit erv, input logic [31:0] ea,
                               input bit eiv, input logic [31:0] epc);
        vec_t t;
        t.rst = rst; t.req_ready = rr; t.id_rdy = ir; t.redir = rd; t.redir_pc = rpc;
        t.exp_rv = erv; t.exp_addr = ea; t.exp_iv = eiv; t.exp_pc = epc;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle, entered and left on a negedge. The imem model answers in
    // order, lat cycles after acceptance; outputs are sampled before the posedge.
    task automatic cycle();
        logic fired;
        logic [31:0] faddr;
        // NOTE: bench inputs are driven with blocking assignments away from the
        // active edge so the DUT never races the stimulus.
        if (q.size() != 0 && q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(q[0].addr);
            void'(q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        s_rv = imem_req_valid; s_addr = imem_req_addr;
        s_iv = id_valid; s_pc = id_pc; s_instr = id_instr;
        fired = imem_req_valid & imem_req_ready;
        faddr = imem_req_addr;
        if (imem_rsp_valid && dut.r_outstanding == '0) begin
            miscompares++;
            $display("FAIL rsp_without_outstanding: cycle %0d", cyc);
        end
        if (int'(dut.r_count) > DEPTH) begin
            miscompares++;
            $display("FAIL occupancy: got %0d, limit %0d", dut.r_count, DEPTH);
        end
        @(posedge clk);
        if (fired) q.push_back('{faddr, cyc + lat});
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        q.delete();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_valid"}, 32'(imem_req_valid), 32'd0);
        check({tag, " id_valid"},  32'(id_valid),       32'd0);
        check({tag, " id_pc"},     id_pc,               32'd0);
        check({tag, " id_instr"},  id_instr,            32'd0);
    endtask

    initial begin
        rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");

        // Streaming, then imem stalls with pc=0x10.
        tbl.push_back(v(1, 1, 1, 0, 0, 1, 32'h00, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h04, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0, 0, 0,      1, 32'h00));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h08, 1, 32'h04));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h0C, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0, 0, 0,      1, 32'h08));
        tbl.push_back(v(0, 0, 1, 0, 0, 1, 32'h10, 1, 32'h0C));
        tbl.push_back(v(0, 0, 1, 0, 0, 1, 32'h10, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 1, 32'h10, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h10, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h14, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0, 0, 0,      1, 32'h10));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h18, 1, 32'h14));
        // Decode stalled for 6 cycles: credit limit, held head, then drain.
        tbl.push_back(v(1, 1, 0, 0, 0, 1, 32'h00, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 32'h04, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 32'h00));
        tbl.push_back(v(0, 1, 1, 0, 0, 0, 0,      1, 32'h00));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h08, 1, 32'h04));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h0C, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0, 0, 0,      1, 32'h08));
        // Redirect coinciding with the only outstanding response: no flush.
        tbl.push_back(v(1, 1, 1, 0, 0,           1, 32'h00, 0, 0));
        tbl.push_back(v(0, 1, 1, 1, 32'h0000_0042, 0, 0,    0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0,           1, 32'h40, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0,           1, 32'h44, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0,           0, 0,      1, 32'h40));
        // PC wrap at the top of the address space.
        tbl.push_back(v(1, 1, 1, 1, 32'hFFFF_FFFF, 0, 0,            0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0,             1, 32'hFFFF_FFFC, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0,             1, 32'h0000_0000, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0,             0, 0,             1, 32'hFFFF_FFFC));

        lat = 1;
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            imem_req_ready = tbl[i].req_ready;
            id_ready       = tbl[i].id_rdy;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].redir_pc;
            cycle();
            redirect_valid = 1'b0;
            check($sformatf("v%0d req_valid", i), 32'(s_rv), 32'(tbl[i].exp_rv));
            if (tbl[i].exp_rv)
                check($sformatf("v%0d req_addr", i), s_addr, tbl[i].exp_addr);
            check($sformatf("v%0d id_valid", i), 32'(s_iv), 32'(tbl[i].exp_iv));
            if (tbl[i].exp_iv) begin
                check($sformatf("v%0d id_pc", i), s_pc, tbl[i].exp_pc);
                check($sformatf("v%0d id_instr", i), s_instr, instr_of(tbl[i].exp_pc));
            end
        end

        // Asynchronous reset mid-burst: a buffered entry and a pending request exist.
        imem_rsp_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async reset");
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check("post-reset req_valid", 32'(s_rv), 32'd1);
        check("post-reset req_addr", s_addr, 32'h0);

        // Redirect with two requests in flight (3-cycle imem): both stale responses
        // are dropped and no request issues until they have returned.
        do_reset();
        lat = 3; imem_req_ready = 1'b1; id_ready = 1'b1;
        cycle();
        cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        cycle();
        redirect_valid = 1'b0;
        check("redir cycle req_valid", 32'(s_rv), 32'd0);
        for (int i = 0; i < 2; i++) begin
            cycle();
            check($sformatf("flush%0d req_valid", i), 32'(s_rv), 32'd0);
            check($sformatf("flush%0d id_valid", i), 32'(s_iv), 32'd0);
        end
        cycle();
        check("target req_valid", 32'(s_rv), 32'd1);
        check("target req_addr", s_addr, 32'h100);
        check("target id_valid", 32'(s_iv), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("refill%0d id_valid", i), 32'(s_iv), 32'd0);
        end
        cycle();
        check("first id_valid after redirect", 32'(s_iv), 32'd1);
        check("first id_pc after redirect", s_pc, 32'h100);
        check("first id_instr after redirect", s_instr, instr_of(32'h100));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
